// File: rtl/mem_pkg.sv
// Shared types and constants for the 16-bit external memory bus initiator.
// Pin polarities follow the memory's active-low enable/write port.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2,
      RESP   = 2'd3
   } mem_master_state_t;

   localparam logic SIZE_HALF = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam logic MEM_ON  = 1'b0;
   localparam logic MEM_OFF = 1'b1;
   localparam logic MEM_WR  = 1'b0;
   localparam logic MEM_RD  = 1'b1;

   localparam int MEM_ADDR_W = 20;
   localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/mem_master_if.sv
// Core-side request/response and memory-side pin bundle for mem_master.
// The master modport is the initiator's view; slave is the core/memory view.
interface mem_master_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic                  req_size;
   logic [ADDR_W-1:0]     req_addr;
   logic [2*DATA_W-1:0]   req_wdata;

   logic                  rsp_valid;
   logic [2*DATA_W-1:0]   rsp_rdata;
   logic                  rsp_err;

   logic                  mem_enable;
   logic                  mem_write;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_enable, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_enable, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_master.sv
// Sequences 16/32-bit core requests into one or two big-endian halfword memory cycles.
// Define MEM_MASTER_ALIGN_CHECK_EN to reject odd word addresses with rsp_err instead of aligning them.
module mem_master
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic           clk,
   input  logic           rst,
   mem_master_if.master   bus
);

   mem_master_state_t     r_state;
   mem_master_state_t     w_next;

   logic                  r_we;
   logic                  r_size;
   logic [ADDR_W-1:0]     r_addr;
   logic [2*DATA_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]     r_memAddr;
   logic [DATA_W-1:0]     r_memWdata;
   logic [DATA_W-1:0]     r_first;
   logic [2*DATA_W-1:0]   r_rdata;

   logic                  w_accept;
   logic                  w_memCycle;
   logic [ADDR_W-1:0]     w_reqAddr;

   assign w_accept   = bus.req_valid && (r_state == IDLE);
   assign w_memCycle = (r_state == FIRST) || (r_state == SECOND);

`ifdef MEM_MASTER_ALIGN_CHECK_EN
   logic                  r_err;
   logic                  w_misalign;

   assign w_misalign = (bus.req_size == SIZE_WORD) && bus.req_addr[0];
   assign w_reqAddr  = bus.req_addr;
   assign bus.rsp_err = r_err && (r_state == RESP);
`else
   // Word accesses are silently forced onto an even halfword, so they never wrap.
   assign w_reqAddr  = (bus.req_size == SIZE_WORD) ? {bus.req_addr[ADDR_W-1:1], 1'b0}
                                                   : bus.req_addr;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
`ifdef MEM_MASTER_ALIGN_CHECK_EN
               w_next = w_misalign ? RESP : FIRST;
`else
               w_next = FIRST;
`endif
            end
         end
         FIRST:   w_next = (r_size == SIZE_WORD) ? SECOND : RESP;
         SECOND:  w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Memory address/data are registered so they hold their last value between accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_size     <= SIZE_HALF;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_first    <= '0;
         r_rdata    <= '0;
`ifdef MEM_MASTER_ALIGN_CHECK_EN
         r_err      <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_we    <= bus.req_we;
                  r_size  <= bus.req_size;
                  r_addr  <= w_reqAddr;
                  r_wdata <= bus.req_wdata;
`ifdef MEM_MASTER_ALIGN_CHECK_EN
                  r_err   <= w_misalign;
                  if (!w_misalign) begin
                     r_memAddr  <= w_reqAddr;
                     r_memWdata <= (bus.req_size == SIZE_WORD) ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                                               : bus.req_wdata[DATA_W-1:0];
                  end
`else
                  r_memAddr  <= w_reqAddr;
                  r_memWdata <= (bus.req_size == SIZE_WORD) ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                                            : bus.req_wdata[DATA_W-1:0];
`endif
               end
            end
            FIRST: begin
               if (!r_we) begin
                  r_first <= bus.mem_rdata;
                  if (r_size == SIZE_HALF) begin
                     r_rdata <= {{DATA_W{1'b0}}, bus.mem_rdata};
                  end
               end
               if (r_size == SIZE_WORD) begin
                  r_memAddr  <= r_addr + 1'b1;
                  r_memWdata <= r_wdata[DATA_W-1:0];
               end
            end
            SECOND: begin
               if (!r_we) begin
                  r_rdata <= {r_first, bus.mem_rdata};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.req_ready  = (r_state == IDLE);
   assign bus.rsp_valid  = (r_state == RESP);
   assign bus.rsp_rdata  = r_rdata;
   assign bus.mem_enable = w_memCycle ? MEM_ON : MEM_OFF;
   assign bus.mem_write  = (w_memCycle && r_we) ? MEM_WR : MEM_RD;
   assign bus.mem_addr   = r_memAddr;
   assign bus.mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: behavioural halfword memory plus a response scoreboard.
// Honours MEM_MASTER_ALIGN_CHECK_EN the same way the design does.
module tb_mem_master;
   import mem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          respEdge;
      bit          chkEdge;
   } exp_t;

   logic        clk;
   logic        rst;
   int          edgeCount;
   int          checkCount;
   int          passCount;
   int          wrCycles;
   int          rdCycles;
   int          rspCount;
   logic [15:0] mem   [256];
   logic [15:0] model [256];
   logic [31:0] lastRdata;
   exp_t        expQ[$];
   int          rspEdges[$];

   mem_master_if #(.ADDR_W(20), .DATA_W(16)) bus();

   mem_master dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   function automatic logic [15:0] pat(input int i);
      return 16'hA500 | 16'(i & 255);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Behavioural memory: combinational read while enabled, write commits on the closing edge.
   assign bus.mem_rdata = (bus.mem_enable == MEM_ON && bus.mem_write == MEM_RD)
                          ? mem[bus.mem_addr[7:0]] : 16'hzzzz;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = pat(i);
      forever begin
         @(posedge clk);
         if (bus.mem_enable == MEM_ON && bus.mem_write == MEM_WR)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      else
         passCount++;
   endtask

   // Pin activity counters and the response side of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.mem_enable == MEM_ON && bus.mem_write == MEM_WR) wrCycles <= wrCycles + 1;
         if (bus.mem_enable == MEM_ON && bus.mem_write == MEM_RD) rdCycles <= rdCycles + 1;
         if (bus.rsp_valid) begin
            rspCount <= rspCount + 1;
            rspEdges.push_back(edgeCount);
            if (expQ.size() == 0) begin
               checkOutput("spuriousRsp", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rspRdata", bus.rsp_rdata, e.rdata);
               checkOutput("rspErr", {31'd0, bus.rsp_err}, {31'd0, e.err});
               if (e.chkEdge) checkOutput("rspLatency", edgeCount, e.respEdge);
            end
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic size, input logic [19:0] addr,
                                input logic [31:0] wdata, input bit hold, output int accEdge);
      exp_t        e;
      logic [19:0] a;
      logic        err;
      bit          accepted;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      accepted = 0;
      accEdge  = -1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (bus.req_ready) begin
            @(posedge clk);
            #1;
            accepted = 1;
            accEdge  = edgeCount;
         end else begin
            @(negedge clk);
         end
      end
      if (!hold) bus.req_valid = 1'b0;
      if (!accepted) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
      end else begin
         a   = addr;
         err = 1'b0;
`ifdef MEM_MASTER_ALIGN_CHECK_EN
         if (size == SIZE_WORD && addr[0]) err = 1'b1;
`else
         if (size == SIZE_WORD) a[0] = 1'b0;
`endif
         e.err      = err;
         e.chkEdge  = !err;
         e.respEdge = accEdge + ((size == SIZE_WORD) ? 2 : 1);
         if (err) begin
            e.rdata = lastRdata;
         end else if (we) begin
            if (size == SIZE_WORD) begin
               model[a[7:0]]        = wdata[31:16];
               model[a[7:0] + 8'd1] = wdata[15:0];
            end else begin
               model[a[7:0]] = wdata[15:0];
            end
            e.rdata = lastRdata;
         end else begin
            e.rdata = (size == SIZE_WORD) ? {model[a[7:0]], model[a[7:0] + 8'd1]}
                                          : {16'h0, model[a[7:0]]};
            lastRdata = e.rdata;
         end
         expQ.push_back(e);
      end
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 50 && expQ.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (expQ.size() != 0) begin
         checkOutput("rspTimeout", expQ.size(), 32'd0);
         expQ.delete();
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      int          acc0;
      int          acc1;
      int          base;
      int          relEdge;
      logic        we;
      logic        size;
      logic [19:0] addr;

      edgeCount = 0;
      checkCount = 0;
      passCount = 0;
      wrCycles = 0;
      rdCycles = 0;
      rspCount = 0;
      lastRdata = 32'h0;
      for (int i = 0; i < 256; i++) model[i] = pat(i);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = SIZE_HALF;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;

      // Dirty the outputs, then reset in the middle of an idle cycle.
      applyStimulus(1'b0, SIZE_HALF, 20'h00021, 32'h0, 0, acc0);
      waitIdle();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstReady", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("rstEnable", {31'd0, bus.mem_enable}, 32'd1);
      checkOutput("rstWrite", {31'd0, bus.mem_write}, 32'd1);
      checkOutput("rstAddr", {12'd0, bus.mem_addr}, 32'd0);
      checkOutput("rstWdata", {16'd0, bus.mem_wdata}, 32'd0);
      checkOutput("rstRspValid", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("rstRdata", bus.rsp_rdata, 32'd0);
      checkOutput("rstErr", {31'd0, bus.rsp_err}, 32'd0);
      lastRdata = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Word store then word load, big-endian halves.
      base = wrCycles;
      applyStimulus(1'b1, SIZE_WORD, 20'h00010, 32'hDEADBEEF, 0, acc0);
      waitIdle();
      checkOutput("memHi", {16'd0, mem[8'h10]}, 32'h0000DEAD);
      checkOutput("memLo", {16'd0, mem[8'h11]}, 32'h0000BEEF);
      checkOutput("wordWrCycles", wrCycles - base, 32'd2);
      applyStimulus(1'b0, SIZE_WORD, 20'h00010, 32'h0, 0, acc0);
      waitIdle();

      // Halfword store uses only the low half of the store data.
      base = wrCycles;
      applyStimulus(1'b1, SIZE_HALF, 20'h00007, 32'h12340005, 0, acc0);
      waitIdle();
      checkOutput("halfMem", {16'd0, mem[8'h07]}, 32'h00000005);
      checkOutput("halfNeighbour", {16'd0, mem[8'h08]}, {16'd0, pat(8)});
      checkOutput("halfWrCycles", wrCycles - base, 32'd1);
      applyStimulus(1'b0, SIZE_HALF, 20'h00007, 32'h0, 0, acc0);
      waitIdle();

      // Odd word address.
      base = rdCycles;
      applyStimulus(1'b0, SIZE_WORD, 20'h00003, 32'h0, 0, acc0);
      waitIdle();
`ifdef MEM_MASTER_ALIGN_CHECK_EN
      checkOutput("misalignRdCycles", rdCycles - base, 32'd0);
`else
      checkOutput("misalignRdCycles", rdCycles - base, 32'd2);
`endif

      // Reset during the second half of a word store.
      applyStimulus(1'b1, SIZE_WORD, 20'h00040, 32'hCAFEF00D, 0, acc0);
      @(posedge clk);
      #1;
      checkOutput("secondEnable", {31'd0, bus.mem_enable}, 32'd0);
      checkOutput("secondAddr", {12'd0, bus.mem_addr}, 32'h00000041);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abortEnable", {31'd0, bus.mem_enable}, 32'd1);
      expQ.delete();
      model[8'h41] = pat(8'h41);
      lastRdata = 32'h0;
      base = rspCount;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      relEdge = edgeCount;
      applyStimulus(1'b0, SIZE_WORD, 20'h00040, 32'h0, 0, acc0);
      checkOutput("acceptAfterRst", acc0, relEdge + 1);
      waitIdle();
      checkOutput("rspAfterAbort", rspCount - base, 32'd1);

      // Back-to-back word loads with req_valid held high.
      rspEdges.delete();
      applyStimulus(1'b0, SIZE_WORD, 20'h00010, 32'h0, 1, acc0);
      applyStimulus(1'b0, SIZE_WORD, 20'h00006, 32'h0, 0, acc1);
      checkOutput("b2bAccept", acc1 - acc0, 32'd4);
      waitIdle();
      if (rspEdges.size() == 2)
         checkOutput("b2bRspGap", rspEdges[1] - rspEdges[0], 32'd4);
      else
         checkOutput("b2bRspCount", rspEdges.size(), 32'd2);

      // A short mixed sequence over a small window.
      for (int i = 0; i < 8; i++) begin
         we   = 1'($urandom_range(0, 1));
         size = 1'($urandom_range(0, 1));
         addr = 20'h00080 + 20'($urandom_range(0, 15));
         applyStimulus(we, size, addr, $urandom, 0, acc0);
         waitIdle();
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
